random_coord_generator: RTL and testbench

Parametrised successor to the snake game's random seed block. It free-runs a counter and a maximal-length Galois LFSR, and mixes the counter into the LFSR on every player key press so the sequence depends on human timing. On request it draws an in-range (x, y) grid coordinate for food placement through a multi-cycle subtractive reduction FSM. It sits between the key inputs and the food/placement logic, and also exports the raw LFSR state as `seed`.

---
 rtl/random_coord_generator_if.sv | 25 ++
 rtl/random_coord_generator.sv | 149 ++++++++++++++
 tb/tb_random_coord_generator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/random_coord_generator_if.sv
`default_nettype none
// ============================================================================
// Module   : random_coord_generator_if
// Brief    : Request/result bundle between the coordinate generator and the
//            food placement logic.
// Revision : 1.0 - initial release
// ============================================================================
interface random_coord_generator_if #(
   parameter int LFSR_W = 16,
   parameter int X_W    = 6,
   parameter int Y_W    = 5
);
   logic              req;
   logic              busy;
   logic              valid;
   logic [X_W-1:0]    coord_x;
   logic [Y_W-1:0]    coord_y;
   logic [LFSR_W-1:0] seed;

   // Placement side: issues requests, consumes coordinates
   modport master (output req, input busy, valid, coord_x, coord_y, seed);
   // Generator side
   modport slave  (input req, output busy, valid, coord_x, coord_y, seed);
endinterface
`default_nettype wire

// File: rtl/random_coord_generator.sv
`default_nettype none
// ============================================================================
// Module   : random_coord_generator
// Brief    : Free-running Galois LFSR stirred by key-press timing, with a
//            multi-cycle subtractive reduction drawing in-range grid coords.
// Revision : 1.0 - initial release
// ============================================================================
module random_coord_generator #(
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED_INIT = 16'd3535,
   parameter int                SHAKE_MOD = 3989,
   parameter int                NKEYS     = 4,
   parameter int                X_W       = 6,
   parameter int                Y_W       = 5,
   parameter int                GRID_X    = 40,
   parameter int                GRID_Y    = 30
) (
   input  wire              OSC_50,
   input  wire              rst,
   input  wire [NKEYS-1:0]  KEY,
   random_coord_generator_if.slave bus
);

   localparam int                 c_SHK_W    = (SHAKE_MOD > 1) ? $clog2(SHAKE_MOD) : 1;
   localparam logic [c_SHK_W-1:0] c_SHK_LAST = c_SHK_W'(SHAKE_MOD - 1);
   // One extra bit so a grid of exactly 2^W still compares correctly
   localparam logic [X_W:0]       c_GRID_X   = (X_W+1)'(GRID_X);
   localparam logic [Y_W:0]       c_GRID_Y   = (Y_W+1)'(GRID_Y);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RED_X = 2'd1,
      S_RED_Y = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   logic [NKEYS-1:0]   r_key_meta;
   logic [NKEYS-1:0]   r_key_sync;
   logic [NKEYS-1:0]   r_key_prev;
   logic               w_entropy;
   logic [c_SHK_W-1:0] r_shaker;
   logic [LFSR_W-1:0]  r_lfsr;
   logic [LFSR_W-1:0]  w_step;
   logic [LFSR_W-1:0]  w_mix;
   logic [LFSR_W-1:0]  w_lfsr_next;
   state_t             r_state;
   state_t             w_state_next;
   logic [X_W-1:0]     r_rx;
   logic [Y_W-1:0]     r_ry;
   logic [X_W-1:0]     r_coord_x;
   logic [Y_W-1:0]     r_coord_y;
   logic               w_x_ge;
   logic               w_y_ge;

   // Two-flop synchroniser plus previous-value register for fall detection
   always_ff @(posedge OSC_50) begin
      if (rst) begin
         r_key_meta <= '1;
         r_key_sync <= '1;
         r_key_prev <= '1;
      end else begin
         r_key_meta <= KEY;
         r_key_sync <= r_key_meta;
         r_key_prev <= r_key_sync;
      end
   end

   // Any key falling (simultaneous falls collapse into one event)
   assign w_entropy = |(r_key_prev & ~r_key_sync);

   // Shaker counts 0..SHAKE_MOD-1 and wraps
   always_ff @(posedge OSC_50) begin
      if (rst)                       r_shaker <= '0;
      else if (r_shaker == c_SHK_LAST) r_shaker <= '0;
      else                           r_shaker <= r_shaker + 1'b1;
   end

   assign w_step      = {1'b0, r_lfsr[LFSR_W-1:1]} ^ (r_lfsr[0] ? TAPS : '0);
   assign w_mix       = w_entropy ? (w_step ^ LFSR_W'(r_shaker)) : w_step;
   // Mixing can in principle cancel to zero, which would lock the LFSR
   assign w_lfsr_next = (w_mix == '0) ? SEED_INIT : w_mix;

   // LFSR advances every cycle
   always_ff @(posedge OSC_50) begin
      if (rst) r_lfsr <= SEED_INIT;
      else     r_lfsr <= w_lfsr_next;
   end

   assign w_x_ge = {1'b0, r_rx} >= c_GRID_X;
   assign w_y_ge = {1'b0, r_ry} >= c_GRID_Y;

   // Draw FSM state register
   always_ff @(posedge OSC_50) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Draw FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.req) w_state_next = S_RED_X;
         S_RED_X: if (!w_x_ge) w_state_next = S_RED_Y;
         S_RED_Y: if (!w_y_ge) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Raw capture, repeated subtraction and result load
   always_ff @(posedge OSC_50) begin
      if (rst) begin
         r_rx      <= '0;
         r_ry      <= '0;
         r_coord_x <= '0;
         r_coord_y <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req) begin
                  r_rx <= r_lfsr[X_W-1:0];
                  r_ry <= r_lfsr[X_W+Y_W-1:X_W];
               end
            end
            S_RED_X: begin
               if (w_x_ge) r_rx <= r_rx - c_GRID_X[X_W-1:0];
            end
            S_RED_Y: begin
               if (w_y_ge) begin
                  r_ry <= r_ry - c_GRID_Y[Y_W-1:0];
               end else begin
                  r_coord_x <= r_rx;
                  r_coord_y <= r_ry;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (r_state != S_IDLE);
   assign bus.valid   = (r_state == S_DONE);
   assign bus.coord_x = r_coord_x;
   assign bus.coord_y = r_coord_y;
   assign bus.seed    = r_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_random_coord_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_random_coord_generator
// Brief    : Self-checking bench for random_coord_generator, one instance with
//            a 40x30 grid and one with a 64x32 grid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_random_coord_generator;

   localparam logic [15:0] SEED_INIT = 16'd3535;
   localparam logic [15:0] TAPS      = 16'hB400;
   localparam int          SHAKE_MOD = 3989;

   logic       clk;
   logic       rst;
   logic [3:0] key_a;
   logic [3:0] key_b;
   int         checks;
   int         errors;

   random_coord_generator_if #(.LFSR_W(16), .X_W(6), .Y_W(5)) bus_a ();
   random_coord_generator_if #(.LFSR_W(16), .X_W(6), .Y_W(5)) bus_b ();

   random_coord_generator #(.GRID_X(40), .GRID_Y(30)) dut_a (
      .OSC_50 (clk),
      .rst    (rst),
      .KEY    (key_a),
      .bus    (bus_a)
   );

   random_coord_generator #(.GRID_X(64), .GRID_Y(32)) dut_b (
      .OSC_50 (clk),
      .rst    (rst),
      .KEY    (key_b),
      .bus    (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [15:0] step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? TAPS : 16'h0);
   endfunction

   function automatic logic [15:0] mix_val(input logic [15:0] s, input int shk, input bit ev);
      logic [15:0] n;
      n = step(s);
      if (ev) n = n ^ 16'(shk);
      if (n == 16'h0) n = SEED_INIT;
      return n;
   endfunction

   // Key levels seen at past edges: a key that was high three edges ago and
   // low two edges ago mixes on this edge.
   logic [15:0] ma_seed, mb_seed;
   int          ma_shk, mb_shk;
   logic [3:0]  ma_k1, ma_k2, ma_k3, mb_k1, mb_k2, mb_k3;

   always @(posedge clk) begin
      if (rst) begin
         ma_seed <= SEED_INIT; mb_seed <= SEED_INIT;
         ma_shk  <= 0;         mb_shk  <= 0;
         ma_k1 <= 4'hF; ma_k2 <= 4'hF; ma_k3 <= 4'hF;
         mb_k1 <= 4'hF; mb_k2 <= 4'hF; mb_k3 <= 4'hF;
      end else begin
         ma_seed <= mix_val(ma_seed, ma_shk, (ma_k3 & ~ma_k2) != 4'h0);
         mb_seed <= mix_val(mb_seed, mb_shk, (mb_k3 & ~mb_k2) != 4'h0);
         ma_shk  <= (ma_shk + 1) % SHAKE_MOD;
         mb_shk  <= (mb_shk + 1) % SHAKE_MOD;
         ma_k3 <= ma_k2; ma_k2 <= ma_k1; ma_k1 <= key_a;
         mb_k3 <= mb_k2; mb_k2 <= mb_k1; mb_k1 <= key_b;
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus_a.seed !== SEED_INIT) begin errors++; $display("FAIL reset_seed: got %0d expected %0d", bus_a.seed, SEED_INIT); end
      checks++; if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_a.valid); end
      checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
      checks++; if (bus_a.coord_x !== 6'd0) begin errors++; $display("FAIL reset_coord_x: got %0d expected 0", bus_a.coord_x); end
      checks++; if (bus_a.coord_y !== 5'd0) begin errors++; $display("FAIL reset_coord_y: got %0d expected 0", bus_a.coord_y); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus_a.seed !== 16'hB2E7) begin errors++; $display("FAIL first_step: got %h expected b2e7", bus_a.seed); end
   endtask

   task automatic test_period();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 65535; k++) begin
         @(negedge clk);
         checks++;
         if (bus_a.seed === 16'h0) begin errors++; if (errors < 10) $display("FAIL period_nonzero: got 0 expected nonzero at step %0d", k); end
         checks++;
         if (bus_a.seed !== ma_seed) begin errors++; if (errors < 10) $display("FAIL period_track: got %h expected %h at step %0d", bus_a.seed, ma_seed, k); end
      end
      checks++; if (bus_a.seed !== SEED_INIT) begin errors++; $display("FAIL period_return: got %0d expected %0d", bus_a.seed, SEED_INIT); end
   endtask

   // Press keys with the given pattern and check one mix, then plain steps
   task automatic press_and_check(input logic [3:0] pattern, input string name);
      logic [15:0] pre, expv;
      int          sh;
      key_a = 4'hF;
      repeat (4) @(negedge clk);
      key_a = pattern;
      @(negedge clk);
      @(negedge clk);
      pre = ma_seed; sh = ma_shk;
      expv = step(pre) ^ 16'(sh);
      if (expv == 16'h0) expv = SEED_INIT;
      @(negedge clk);
      checks++; if (bus_a.seed !== expv) begin errors++; $display("FAIL %s_mix: got %h expected %h", name, bus_a.seed, expv); end
      // Held low, then released: no further mixing
      for (int i = 0; i < 16; i++) begin
         pre = ma_seed;
         if (i == 8) key_a = 4'hF;
         @(negedge clk);
         checks++; if (bus_a.seed !== step(pre)) begin errors++; $display("FAIL %s_nomix: got %h expected %h", name, bus_a.seed, step(pre)); end
      end
   endtask

   task automatic test_key_mix();
      press_and_check(4'b1110, "key0");
      press_and_check(4'b1010, "key0_key2");
      press_and_check(4'b0111, "key3");
   endtask

   task automatic test_range_draw();
      logic [15:0] raw;
      int ex, ey, elat, lat;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (i > 0) begin
            checks++; if (bus_a.coord_x !== 6'(ex)) begin errors++; $display("FAIL hold_x: got %0d expected %0d", bus_a.coord_x, ex); end
         end
         if ($urandom_range(0, 3) == 0) key_a = 4'($urandom);
         raw  = ma_seed;
         ex   = int'(raw[5:0]) % 40;
         ey   = int'(raw[10:6]) % 30;
         elat = 3 + int'(raw[5:0]) / 40 + int'(raw[10:6]) / 30;
         bus_a.req = 1'b1;
         @(negedge clk);
         bus_a.req = 1'b0;
         lat = 1;
         while (bus_a.valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
         checks++; if (lat != elat) begin errors++; $display("FAIL draw_latency: got %0d expected %0d raw %h", lat, elat, raw); end
         checks++; if (bus_a.coord_x !== 6'(ex)) begin errors++; $display("FAIL draw_x: got %0d expected %0d raw %h", bus_a.coord_x, ex, raw); end
         checks++; if (bus_a.coord_y !== 5'(ey)) begin errors++; $display("FAIL draw_y: got %0d expected %0d raw %h", bus_a.coord_y, ey, raw); end
         @(negedge clk);
         checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL draw_busy_fall: got %b expected 0", bus_a.busy); end
      end
      key_a = 4'hF;
   endtask

   task automatic test_no_reduction();
      logic [15:0] raws [6];
      bus_b.req = 1'b1;
      for (int k = 0; k < 24; k++) begin
         if (k % 4 == 0) raws[k/4] = mb_seed;
         checks++;
         if (bus_b.valid !== ((k % 4) == 3)) begin errors++; $display("FAIL norm_valid: got %b at cycle c+%0d", bus_b.valid, k); end
         if (k % 4 == 3) begin
            checks++; if (bus_b.coord_x !== raws[(k-3)/4][5:0]) begin errors++; $display("FAIL norm_x: got %0d expected %0d", bus_b.coord_x, raws[(k-3)/4][5:0]); end
            checks++; if (bus_b.coord_y !== raws[(k-3)/4][10:6]) begin errors++; $display("FAIL norm_y: got %0d expected %0d", bus_b.coord_y, raws[(k-3)/4][10:6]); end
         end
         @(negedge clk);
      end
      bus_b.req = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_req_busy();
      logic [15:0] raw;
      int nvalid, lat, elat;
      raw  = ma_seed;
      elat = 3 + int'(raw[5:0]) / 40 + int'(raw[10:6]) / 30;
      bus_a.req = 1'b1;
      nvalid = 0; lat = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == elat) bus_a.req = 1'b0;
         if (bus_a.valid === 1'b1) begin nvalid++; if (lat == 0) lat = k; end
      end
      bus_a.req = 1'b0;
      checks++; if (nvalid != 1) begin errors++; $display("FAIL busy_req_count: got %0d expected 1", nvalid); end
      checks++; if (lat != elat) begin errors++; $display("FAIL busy_req_latency: got %0d expected %0d", lat, elat); end
      checks++; if (bus_a.coord_x !== 6'(int'(raw[5:0]) % 40)) begin errors++; $display("FAIL busy_req_x: got %0d expected %0d", bus_a.coord_x, int'(raw[5:0]) % 40); end
   endtask

   task automatic test_collision();
      logic [15:0] raw, expv;
      int sh, lat;
      key_a = 4'hF;
      repeat (4) @(negedge clk);
      key_a = 4'b1110;
      @(negedge clk);
      @(negedge clk);
      raw = ma_seed; sh = ma_shk;
      expv = step(raw) ^ 16'(sh);
      if (expv == 16'h0) expv = SEED_INIT;
      bus_a.req = 1'b1;
      @(negedge clk);
      bus_a.req = 1'b0;
      checks++; if (bus_a.seed !== expv) begin errors++; $display("FAIL collide_mix: got %h expected %h", bus_a.seed, expv); end
      lat = 1;
      while (bus_a.valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
      checks++; if (bus_a.coord_x !== 6'(int'(raw[5:0]) % 40)) begin errors++; $display("FAIL collide_x: got %0d expected %0d", bus_a.coord_x, int'(raw[5:0]) % 40); end
      checks++; if (bus_a.coord_y !== 5'(int'(raw[10:6]) % 30)) begin errors++; $display("FAIL collide_y: got %0d expected %0d", bus_a.coord_y, int'(raw[10:6]) % 30); end
      key_a = 4'hF;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_abort();
      int nvalid;
      bus_a.req = 1'b1;
      @(negedge clk);
      bus_a.req = 1'b0;
      checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL abort_in_red_x: got busy %b expected 1", bus_a.busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus_a.busy); end
      checks++; if (bus_a.coord_x !== 6'd0) begin errors++; $display("FAIL abort_x: got %0d expected 0", bus_a.coord_x); end
      checks++; if (bus_a.coord_y !== 5'd0) begin errors++; $display("FAIL abort_y: got %0d expected 0", bus_a.coord_y); end
      nvalid = 0;
      for (int k = 0; k < 8; k++) begin
         if (bus_a.valid === 1'b1) nvalid++;
         @(negedge clk);
      end
      checks++; if (nvalid != 0) begin errors++; $display("FAIL abort_valid: got %0d pulses expected 0", nvalid); end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      key_a = 4'hF; key_b = 4'hF;
      bus_a.req = 1'b0; bus_b.req = 1'b0;
      test_reset();
      test_period();
      test_key_mix();
      test_range_draw();
      test_no_reduction();
      test_req_busy();
      test_collision();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
